// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: SPI mode-0 master byte engine between the TX and RX FIFOs
// Ports: clk, reset (synchronous, active-high)
//        div          SCK half-period length minus 1, latched at byte start
//        rx_en        push received bytes to the RX FIFO, latched at byte start
//        tx_valid/tx_data/tx_pop       first-word-fall-through TX FIFO head and pop strobe
//        rx_has_space/rx_push/rx_data  RX FIFO handshake and received byte
//        sck/mosi/miso                 SPI pins (sck idle low, mosi idle high)
//        busy         high while a byte is in flight
module spi_byte_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] div,
    input  logic       rx_en,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_pop,
    input  logic       rx_has_space,
    output logic       rx_push,
    output logic [7:0] rx_data,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t     r_state, w_state;
    logic [7:0] r_tx, w_tx, r_rx, w_rx, r_div, w_div, r_cnt, w_cnt, r_rx_data, w_rx_data;
    logic [2:0] r_bit, w_bit;
    logic       r_rx_en, w_rx_en, r_sck, w_sck, r_mosi, w_mosi, r_busy, w_busy, r_push, w_push;
    logic       w_start;
    // RX space is checked only here, so a started byte can always be pushed at its end
    assign w_start = tx_valid && (!rx_en || rx_has_space);
    assign tx_pop  = (r_state == IDLE) && w_start;
    assign sck     = r_sck;
    assign mosi    = r_mosi;
    assign busy    = r_busy;
    assign rx_push = r_push;
    assign rx_data = r_rx_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tx      <= 8'd0;
            r_rx      <= 8'd0;
            r_div     <= 8'd0;
            r_cnt     <= 8'd0;
            r_bit     <= 3'd0;
            r_rx_en   <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b0;
            r_push    <= 1'b0;
            r_rx_data <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_tx      <= w_tx;
            r_rx      <= w_rx;
            r_div     <= w_div;
            r_cnt     <= w_cnt;
            r_bit     <= w_bit;
            r_rx_en   <= w_rx_en;
            r_sck     <= w_sck;
            r_mosi    <= w_mosi;
            r_busy    <= w_busy;
            r_push    <= w_push;
            r_rx_data <= w_rx_data;
        end
    end
    always_comb begin
        w_state   = r_state;
        w_tx      = r_tx;
        w_rx      = r_rx;
        w_div     = r_div;
        w_cnt     = r_cnt;
        w_bit     = r_bit;
        w_rx_en   = r_rx_en;
        w_sck     = r_sck;
        w_mosi    = r_mosi;
        w_busy    = r_busy;
        w_push    = 1'b0;
        w_rx_data = r_rx_data;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_tx    = tx_data;
                    w_div   = div;
                    w_rx_en = rx_en;
                    w_bit   = 3'd7;
                    w_cnt   = div;
                    w_mosi  = tx_data[7];
                    w_busy  = 1'b1;
                    w_state = LOW;
                end
            end
            LOW: begin
                if (r_cnt != 8'd0) begin
                    w_cnt = r_cnt - 8'd1;
                end else begin
                    // rising SCK edge: capture MISO
                    w_rx    = {r_rx[6:0], miso};
                    w_sck   = 1'b1;
                    w_cnt   = r_div;
                    w_state = HIGH;
                end
            end
            HIGH: begin
                if (r_cnt != 8'd0) begin
                    w_cnt = r_cnt - 8'd1;
                end else if (r_bit != 3'd0) begin
                    // falling SCK edge: present the next bit
                    w_sck   = 1'b0;
                    w_bit   = r_bit - 3'd1;
                    w_tx    = {r_tx[6:0], 1'b0};
                    w_mosi  = r_tx[6];
                    w_cnt   = r_div;
                    w_state = LOW;
                end else begin
                    w_sck   = 1'b0;
                    w_mosi  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                    if (r_rx_en) begin
                        w_rx_data = r_rx;
                        w_push    = 1'b1;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_byte_shifter.sv
// tb_spi_byte_shifter: randomized and directed checks of spi_byte_shifter against an SPI slave model
module tb_spi_byte_shifter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] div = 8'd0;
    logic       rx_en = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_pop;
    logic       rx_has_space = 1'b0;
    logic       rx_push;
    logic [7:0] rx_data;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       busy;
    logic       loop = 1'b0;
    logic [7:0] slave_byte = 8'd0;
    int n_cmp = 0;
    int n_bad = 0;
    spi_byte_shifter dut (
        .clk(clk), .reset(reset), .div(div), .rx_en(rx_en), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_pop(tx_pop), .rx_has_space(rx_has_space), .rx_push(rx_push),
        .rx_data(rx_data), .sck(sck), .mosi(mosi), .miso(miso), .busy(busy)
    );
    always #5 clk = ~clk;
    // slave model: shifts slave_byte out MSB-first, one bit per SCK rise, or echoes MOSI
    int         cyc = 0, viol = 0, hrun = 0, blen = 0, pulses = 0;
    logic [2:0] rise_cnt = 3'd0;
    logic [7:0] mon_tx = 8'd0;
    logic       p_sck = 1'b0, p_busy = 1'b0, p_mosi = 1'b1, p_pop = 1'b0, p_rst = 1'b1;
    int         pop_q[$], end_q[$], push_q[$], hw_q[$], pulse_q[$];
    logic [7:0] rx_q[$], tx_q[$];
    assign miso = loop ? mosi : slave_byte[3'd7 - rise_cnt];
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            p_sck = 1'b0; p_busy = 1'b0; p_mosi = 1'b1; p_pop = 1'b0; p_rst = 1'b1;
            hrun = 0; blen = 0;
        end else begin
            if (sck && !p_sck) begin
                mon_tx = {mon_tx[6:0], mosi};
                pulses++;
                rise_cnt = rise_cnt + 3'd1;
            end
            if (sck) hrun++;
            else if (p_sck) begin hw_q.push_back(hrun); hrun = 0; end
            if (busy) blen++;
            else if (p_busy) begin
                end_q.push_back(cyc); tx_q.push_back(mon_tx); pulse_q.push_back(pulses); blen = 0;
            end
            if (tx_pop) begin
                pop_q.push_back(cyc);
                if (busy || !tx_valid || (rx_en && !rx_has_space)) viol++;
                mon_tx = 8'd0; pulses = 0; rise_cnt = 3'd0;
            end
            if (rx_push) begin rx_q.push_back(rx_data); push_q.push_back(cyc); end
            if (mosi !== p_mosi && !(p_sck && !sck) && !p_pop && !p_rst) viol++;
            if (!busy && (sck || !mosi)) viol++;
            p_sck = sck; p_busy = busy; p_mosi = mosi; p_pop = tx_pop; p_rst = 1'b0;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask
    task automatic flush();
        pop_q.delete(); end_q.delete(); push_q.delete(); hw_q.delete();
        pulse_q.delete(); rx_q.delete(); tx_q.delete();
    endtask
    task automatic wait_q(input string tag, input int which, input int n, input int budget);
        for (int i = 0; i < budget && (which == 0 ? pop_q.size() : end_q.size()) < n; i++) tick();
        chk(tag, which == 0 ? pop_q.size() : end_q.size(), n);
    endtask
    task automatic run_byte(input logic [7:0] b, input logic [7:0] d, input logic [7:0] sb,
                            input logic ren, input logic sp, input logic lp);
        int exp_len = 16 * (int'(d) + 1) + 1;
        int bad = 0;
        flush();
        drive_edge();
        tx_data = b; div = d; rx_en = ren; rx_has_space = sp; slave_byte = sb; loop = lp;
        tx_valid = 1'b1;
        wait_q("pop", 0, 1, 4);
        drive_edge();
        tx_valid = 1'b0; tx_data = ~b; div = 8'($urandom); rx_en = ~ren;
        wait_q("end", 1, 1, exp_len + 8);
        tick();
        chk("byte_len", end_q[0] - pop_q[0], exp_len);
        chk("mosi_byte", tx_q[0], b);
        chk("sck_pulses", pulse_q[0], 8);
        chk("sck_high_cnt", hw_q.size(), 8);
        foreach (hw_q[i]) if (hw_q[i] != int'(d) + 1) bad++;
        chk("sck_high_w", bad, 0);
        chk("push_cnt", rx_q.size(), {31'd0, ren});
        if (ren) begin
            chk("rx_data", rx_q[0], lp ? b : sb);
            chk("push_at_end", push_q[0], end_q[0]);
        end
        chk("idle_mosi", mosi, 1);
        chk("idle_busy", busy, 0);
    endtask
    initial begin
        logic [7:0] sb;
        int found;
        repeat (3) drive_edge();
        reset = 1'b0;
        tick();
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pop", tx_pop, 0);
        chk("rst_push", rx_push, 0);
        chk("rst_rx_data", rx_data, 0);
        run_byte(8'hA5, 8'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        run_byte(8'h3C, 8'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        // back-to-back bytes with loopback
        flush();
        drive_edge();
        tx_data = 8'h12; div = 8'd0; rx_en = 1'b1; rx_has_space = 1'b1; loop = 1'b1; tx_valid = 1'b1;
        wait_q("b2b_pop1", 0, 1, 4);
        drive_edge();
        tx_data = 8'h34;
        wait_q("b2b_pop2", 0, 2, 40);
        drive_edge();
        tx_valid = 1'b0;
        wait_q("b2b_end", 1, 2, 40);
        tick();
        chk("b2b_gap", pop_q[1], end_q[0]);
        chk("b2b_push_cnt", rx_q.size(), 2);
        chk("b2b_rx0", rx_q[0], 8'h12);
        chk("b2b_rx1", rx_q[1], 8'h34);
        chk("b2b_mosi1", tx_q[1], 8'h34);
        // RX FIFO full holds off the start
        flush();
        sb = 8'($urandom);
        drive_edge();
        tx_data = 8'h69; div = 8'd1; rx_en = 1'b1; rx_has_space = 1'b0; slave_byte = sb; loop = 1'b0;
        tx_valid = 1'b1;
        #1 chk("stall_pop0", tx_pop, 0);
        repeat (10) tick();
        chk("stall_pops", pop_q.size(), 0);
        chk("stall_sck", sck, 0);
        chk("stall_busy", busy, 0);
        drive_edge();
        rx_has_space = 1'b1;
        #1 chk("pop_on_space", tx_pop, 1);
        wait_q("stall_pop", 0, 1, 4);
        drive_edge();
        tx_valid = 1'b0;
        wait_q("stall_end", 1, 1, 50);
        tick();
        chk("stall_len", end_q[0] - pop_q[0], 33);
        chk("stall_rx", rx_q[0], sb);
        run_byte(8'hFF, 8'd0, 8'h5A, 1'b0, 1'b0, 1'b1);
        // reset during the HIGH phase of bit 4
        flush();
        drive_edge();
        tx_data = 8'h96; div = 8'd3; rx_en = 1'b1; rx_has_space = 1'b1; loop = 1'b1; tx_valid = 1'b1;
        wait_q("rst_pop", 0, 1, 4);
        drive_edge();
        tx_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (sck && rise_cnt == 3'd4) found = 1;
        end
        chk("reach_bit4", found, 1);
        drive_edge();
        reset = 1'b1;
        drive_edge();
        reset = 1'b0;
        tick();
        chk("mid_rst_sck", sck, 0);
        chk("mid_rst_mosi", mosi, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_push", rx_push, 0);
        repeat (5) tick();
        chk("mid_rst_no_push", rx_q.size(), 0);
        run_byte(8'hC3, 8'd1, 8'h00, 1'b1, 1'b1, 1'b1);
        run_byte(8'h5A, 8'd255, 8'($urandom), 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++)
            run_byte(8'($urandom), 8'($urandom_range(0, 6)), 8'($urandom),
                     1'($urandom), 1'b1, 1'($urandom));
        chk("protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
